// File: rtl/seq_tx_pkg.sv
// Shared state encoding and counter widths for the serial pattern transmitter.
package seq_tx_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} seq_tx_state_t;

   localparam int SEQ_TX_GAP_W = 8;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register presenting its MSB; load wins over shift.
// One cycle from load/shift to msb; no flow control, the owner sequences it.
module seq_shift_reg #(
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serialises load_data MSB first, first bit one cycle after the load handshake; optional SEQ_TX_REPEAT_EN.
// load_ready is low in SHIFT and GAP; load_valid is ignored there and nothing is queued.
module serial_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int   WIDTH      = 10,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_BIT   = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             serial_out,
   output logic             out_valid,
   output logic             done,
   output logic             busy
`ifdef SEQ_TX_REPEAT_EN
   ,
   input  logic             repeat_en
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [SEQ_TX_GAP_W-1:0] GAP_LAST =
      SEQ_TX_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   seq_tx_state_t state, state_n;
   logic [CW-1:0]           bit_cnt, bit_cnt_n;
   logic [SEQ_TX_GAP_W-1:0] gap_cnt, gap_cnt_n;
   logic serial_out_n, out_valid_n, done_n, busy_n, load_ready_n;
   logic start, reload;
   logic sr_load, sr_shift, sr_msb;
   logic [WIDTH-1:0] sr_din, pat;

`ifdef SEQ_TX_REPEAT_EN
   logic [WIDTH-1:0] shadow;
   logic             rep_pend, rep_pend_n;
`endif

   // The shifter holds only the bits still to be sent; the first bit goes straight to serial_out.
   seq_shift_reg #(.WIDTH(WIDTH)) u_sr (
      .clock (clock),
      .reset (reset),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (sr_din),
      .msb   (sr_msb)
   );

   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      gap_cnt_n    = gap_cnt;
      start        = 1'b0;
      reload       = 1'b0;
      serial_out_n = IDLE_BIT;
      out_valid_n  = 1'b0;
      done_n       = 1'b0;
      sr_load      = 1'b0;
      sr_shift     = 1'b0;
      sr_din       = '0;
      pat          = load_data;
`ifdef SEQ_TX_REPEAT_EN
      rep_pend_n   = rep_pend;
`endif

      unique case (state)
         IDLE: begin
            if (load_valid && load_ready) begin
               start = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_cnt != '0) begin
               serial_out_n = sr_msb;
               out_valid_n  = 1'b1;
               sr_shift     = 1'b1;
               bit_cnt_n    = bit_cnt - 1'b1;
               done_n       = (bit_cnt == CW'(1));
            end else begin
`ifdef SEQ_TX_REPEAT_EN
               rep_pend_n = repeat_en && (GAP_CYCLES > 0);
               if (repeat_en && (GAP_CYCLES == 0)) begin
                  reload = 1'b1;
               end else
`endif
               if (GAP_CYCLES > 0) begin
                  state_n   = GAP;
                  gap_cnt_n = GAP_LAST;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
`ifdef SEQ_TX_REPEAT_EN
               if (rep_pend) begin
                  reload     = 1'b1;
                  rep_pend_n = 1'b0;
               end else
`endif
               state_n = IDLE;
            end else begin
               gap_cnt_n = gap_cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (start || reload) begin
`ifdef SEQ_TX_REPEAT_EN
         if (reload) begin
            pat = shadow;
         end
`endif
         state_n      = SHIFT;
         bit_cnt_n    = CNT_LAST;
         serial_out_n = pat[WIDTH-1];
         out_valid_n  = 1'b1;
         sr_load      = 1'b1;
         sr_din       = {pat[WIDTH-2:0], 1'b0};
      end

      busy_n       = (state_n != IDLE);
      load_ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         serial_out <= IDLE_BIT;
         out_valid  <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         gap_cnt    <= gap_cnt_n;
         serial_out <= serial_out_n;
         out_valid  <= out_valid_n;
         done       <= done_n;
         busy       <= busy_n;
         load_ready <= load_ready_n;
      end
   end

`ifdef SEQ_TX_REPEAT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow   <= '0;
         rep_pend <= 1'b0;
      end else begin
         rep_pend <= rep_pend_n;
         if (start) begin
            shadow <= load_data;
         end
      end
   end
`endif

endmodule
